// File: rtl/multiplexed_column_pkg.sv
// Shared configuration, types and FSM states for the multiplexed TNN column scheduler.
package multiplexed_column_pkg;

    localparam int P      = 64;
    localparam int Q      = 2;
    localparam int N_NET  = 2;
    localparam int T_SLOT = 8;
    localparam int TW     = $clog2(T_SLOT);
    localparam int F      = N_NET * T_SLOT;
    localparam int NID_W  = $clog2(N_NET);
    localparam int FC_W   = $clog2(F);

    typedef logic [TW-1:0] spike_time_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } sched_state_e;

endpackage

// File: rtl/spike_time_bank.sv
// Ping-pong first-spike recorder for N_NET x P input lines plus the replay time comparator.
module spike_time_bank
    import multiplexed_column_pkg::*;
(
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    swap,
    input  logic                    rec_en,
    input  logic [N_NET-1:0][P-1:0] data_in,
    input  spike_time_t             rec_time,
    input  logic [NID_W-1:0]        rep_net,
    input  spike_time_t             rep_t,
    output logic [P-1:0]            rep_hit
);

    // bank_sel_reg is the bank being recorded; the other one is replayed
    logic                               bank_sel_reg;
    logic                               rep_bank;
    logic [1:0][N_NET-1:0][P-1:0]       valid_reg;
    spike_time_t                        time_reg [2][N_NET][P];

    assign rep_bank = ~bank_sel_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            bank_sel_reg <= 1'b0;
            valid_reg    <= '0;
        end else if (swap) begin
            bank_sel_reg        <= rep_bank;
            valid_reg[rep_bank] <= '0;
        end else if (rec_en) begin
            for (int n = 0; n < N_NET; n++) begin
                for (int i = 0; i < P; i++) begin
                    if (data_in[n][i] && !valid_reg[bank_sel_reg][n][i]) begin
                        valid_reg[bank_sel_reg][n][i] <= 1'b1;
                        time_reg[bank_sel_reg][n][i]  <= rec_time;
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_replay
            assign rep_hit[gi] = valid_reg[rep_bank][rep_net][gi]
                              && (time_reg[rep_bank][rep_net][gi] == rep_t);
        end
    endgenerate

endmodule

// File: rtl/multiplexed_column_sched.sv
// Time-multiplexes N_NET spike networks onto one TNN column: record in frame f, replay and
// capture per slot in frame f+1, then publish per-network first-spike results.
module multiplexed_column_sched
    import multiplexed_column_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            grst,
    input  logic [N_NET-1:0][P-1:0]         data_in,
    input  logic [Q-1:0]                    col_out,
    output logic [P-1:0]                    col_in,
    output logic                            col_grst,
    output logic [NID_W-1:0]                col_net_id,
    output logic [N_NET-1:0][Q-1:0][TW-1:0] out_time,
    output logic [N_NET-1:0][Q-1:0]         out_valid,
    output logic                            result_valid,
    output logic                            frame_short
);

    localparam logic [FC_W-1:0] FC_LAST = FC_W'(F - 1);

    sched_state_e     state_reg, state_next;
    logic [FC_W-1:0]  fc_reg, fc_next;
    logic             short_next;
    logic             run, rec_en;
    logic [NID_W-1:0] slot_k;
    spike_time_t      slot_t, rec_time;
    logic [P-1:0]     rep_hit;

    logic [P-1:0]     col_in_reg;
    logic             col_grst_reg;
    logic [NID_W-1:0] col_net_id_reg;
    logic             frame_short_reg, result_valid_reg;

    logic             cap_run_reg, cap_grst_reg;
    logic [FC_W-1:0]  cap_fc_reg;
    logic [NID_W-1:0] cap_k;
    spike_time_t      cap_t;
    logic             frame_done, frame_trunc;
    logic [N_NET-1:0] slot_done;

    logic [N_NET-1:0][Q-1:0][TW-1:0] scr_time_reg, cap_time, res_time, out_time_reg;
    logic [N_NET-1:0][Q-1:0]         scr_valid_reg, cap_valid, res_valid, out_valid_reg;

    assign run      = (state_reg == RUN);
    assign rec_en   = run && !grst;
    assign slot_k   = fc_reg[FC_W-1:TW];
    assign slot_t   = fc_reg[TW-1:0];
    assign rec_time = fc_reg[FC_W-1:NID_W];

    always_comb begin
        state_next = state_reg;
        fc_next    = fc_reg;
        short_next = 1'b0;
        if (grst) begin
            state_next = RUN;
            fc_next    = '0;
            short_next = run && (fc_reg != FC_LAST);
        end else if (run) begin
            if (fc_reg == FC_LAST) begin
                state_next = HOLD;
            end else begin
                fc_next = fc_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            fc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            fc_reg    <= fc_next;
        end
    end

    spike_time_bank u_bank (
        .clk      (clk),
        .srst     (rst),
        .swap     (grst),
        .rec_en   (rec_en),
        .data_in  (data_in),
        .rec_time (rec_time),
        .rep_net  (slot_k),
        .rep_t    (slot_t),
        .rep_hit  (rep_hit)
    );

    // The cap_* registers delay fc by one cycle so capture lines up with the registered col_* outputs
    assign cap_k       = cap_fc_reg[FC_W-1:TW];
    assign cap_t       = cap_fc_reg[TW-1:0];
    assign frame_done  = cap_run_reg && (cap_fc_reg == FC_LAST);
    assign frame_trunc = cap_run_reg && cap_grst_reg && !frame_done;

    always_comb begin
        cap_time  = scr_time_reg;
        cap_valid = scr_valid_reg;
        if (cap_run_reg) begin
            for (int q = 0; q < Q; q++) begin
                if (col_out[q] && !scr_valid_reg[cap_k][q]) begin
                    cap_valid[cap_k][q] = 1'b1;
                    cap_time[cap_k][q]  = cap_t;
                end
            end
        end
    end

    // On truncation the slot in progress is incomplete, so only earlier slots are published
    generate
        for (genvar gi = 0; gi < N_NET; gi++) begin : g_result
            assign slot_done[gi] = frame_done || (NID_W'(gi) < cap_k);
            assign res_valid[gi] = slot_done[gi] ? cap_valid[gi] : '0;
            assign res_time[gi]  = slot_done[gi] ? cap_time[gi]  : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            col_in_reg       <= '0;
            col_grst_reg     <= 1'b0;
            col_net_id_reg   <= '0;
            cap_run_reg      <= 1'b0;
            cap_grst_reg     <= 1'b0;
            cap_fc_reg       <= '0;
            frame_short_reg  <= 1'b0;
            result_valid_reg <= 1'b0;
            out_valid_reg    <= '0;
            out_time_reg     <= '0;
            scr_valid_reg    <= '0;
            scr_time_reg     <= '0;
        end else begin
            col_in_reg       <= run ? rep_hit : '0;
            col_grst_reg     <= run && (slot_t == '0);
            col_net_id_reg   <= run ? slot_k : '0;
            cap_run_reg      <= run;
            cap_grst_reg     <= grst;
            cap_fc_reg       <= fc_reg;
            frame_short_reg  <= short_next;
            result_valid_reg <= frame_done || frame_trunc;
            if (frame_done || frame_trunc) begin
                out_valid_reg <= res_valid;
                out_time_reg  <= res_time;
            end
            if (cap_grst_reg || frame_done) begin
                scr_valid_reg <= '0;
                scr_time_reg  <= '0;
            end else begin
                scr_valid_reg <= cap_valid;
                scr_time_reg  <= cap_time;
            end
        end
    end

    assign col_in       = col_in_reg;
    assign col_grst     = col_grst_reg;
    assign col_net_id   = col_net_id_reg;
    assign out_time     = out_time_reg;
    assign out_valid    = out_valid_reg;
    assign result_valid = result_valid_reg;
    assign frame_short  = frame_short_reg;

endmodule

// File: tb/tb_multiplexed_column_sched.sv
// Directed per-cycle vector tables for multiplexed_column_sched; cycle 0 of every frame carries grst.
module tb_multiplexed_column_sched;
    import multiplexed_column_pkg::*;

    localparam int MAXC = 19;

    logic                            clk = 1'b0;
    logic                            rst, grst;
    logic [N_NET-1:0][P-1:0]         data_in;
    logic [Q-1:0]                    col_out;
    logic [P-1:0]                    col_in;
    logic                            col_grst;
    logic [NID_W-1:0]                col_net_id;
    logic [N_NET-1:0][Q-1:0][TW-1:0] out_time;
    logic [N_NET-1:0][Q-1:0]         out_valid;
    logic                            result_valid, frame_short;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs are those observed at the start of cycle c; inputs are driven during cycle c
    typedef struct packed {
        logic [N_NET-1:0][P-1:0]         din;
        logic [Q-1:0]                    cout;
        logic [P-1:0]                    col_in;
        logic                            cgrst;
        logic [NID_W-1:0]                nid;
        logic                            rv;
        logic                            fs;
        logic                            chk_out;
        logic [N_NET-1:0][Q-1:0]         ov;
        logic [N_NET-1:0][Q-1:0][TW-1:0] ot;
    } vec_t;

    vec_t vt [0:MAXC-1];

    multiplexed_column_sched dut (
        .clk          (clk),
        .rst          (rst),
        .grst         (grst),
        .data_in      (data_in),
        .col_out      (col_out),
        .col_in       (col_in),
        .col_grst     (col_grst),
        .col_net_id   (col_net_id),
        .out_time     (out_time),
        .out_valid    (out_valid),
        .result_valid (result_valid),
        .frame_short  (frame_short)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Empty full-frame schedule: col_grst at slot starts, slot1 net id, result strobe after frame end
    task automatic prep();
        for (int c = 0; c < MAXC; c++) vt[c] = '0;
        vt[2].cgrst  = 1'b1;
        vt[10].cgrst = 1'b1;
        for (int c = 10; c <= 17; c++) vt[c].nid = NID_W'(1);
        vt[18].rv      = 1'b1;
        vt[18].chk_out = 1'b1;
    endtask

    task automatic run_frame(input string tag, input int len);
        for (int c = 0; c < len; c++) begin
            tick();
            chk({tag, " col_in"}, c, 64'(col_in), 64'(vt[c].col_in));
            chk({tag, " col_grst"}, c, 64'(col_grst), 64'(vt[c].cgrst));
            chk({tag, " col_net_id"}, c, 64'(col_net_id), 64'(vt[c].nid));
            chk({tag, " result_valid"}, c, 64'(result_valid), 64'(vt[c].rv));
            chk({tag, " frame_short"}, c, 64'(frame_short), 64'(vt[c].fs));
            if (vt[c].chk_out) begin
                chk({tag, " out_valid"}, c, 64'(out_valid), 64'(vt[c].ov));
                chk({tag, " out_time"}, c, 64'(out_time), 64'(vt[c].ot));
            end
            grst    = (c == 0);
            data_in = vt[c].din;
            col_out = vt[c].cout;
        end
    endtask

    task automatic check_zero(input string tag, input int c);
        chk({tag, " col_in"}, c, 64'(col_in), 64'd0);
        chk({tag, " col_grst"}, c, 64'(col_grst), 64'd0);
        chk({tag, " col_net_id"}, c, 64'(col_net_id), 64'd0);
        chk({tag, " out_valid"}, c, 64'(out_valid), 64'd0);
        chk({tag, " out_time"}, c, 64'(out_time), 64'd0);
        chk({tag, " result_valid"}, c, 64'(result_valid), 64'd0);
        chk({tag, " frame_short"}, c, 64'(frame_short), 64'd0);
    endtask

    initial begin
        rst = 1'b1; grst = 1'b0; data_in = '0; col_out = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_zero("reset", c);
        end
        rst = 1'b0;
        tick();

        // A: first frame replays the empty bank; records [0][5]@fc4, [1][9]@fc7
        prep();
        vt[0].din[1][3]  = 1'b1;  // on grst cycle: ignored
        vt[5].din[0][5]  = 1'b1;
        vt[8].din[1][9]  = 1'b1;
        vt[11].din[0][5] = 1'b1;  // repeat: ignored
        vt[17].din[0][7] = 1'b1;  // during HOLD: ignored
        run_frame("A", 19);

        // B: replay A; column fires q0@slot1 t1, q1@slot1 t6 (second q1 spike ignored)
        prep();
        vt[4].col_in[5]  = 1'b1;
        vt[13].col_in[9] = 1'b1;
        vt[11].cout = 2'b01;
        vt[16].cout = 2'b10;
        vt[17].cout = 2'b10;
        vt[1].din[0][2] = 1'b1;
        vt[18].ov[1] = 2'b11;
        vt[18].ot[1][1] = 3'd6;
        vt[18].ot[1][0] = 3'd1;
        run_frame("B", 19);

        // C: replay B ([0][2]@t0); q0 fires slot0 t3, q1 fires in slot1 which will be truncated
        prep();
        vt[2].col_in[2] = 1'b1;
        vt[5].cout  = 2'b01;
        vt[10].cout = 2'b10;
        vt[7].din[1][1] = 1'b1;
        run_frame("C", 11);

        // D: grst at fc=10 -> frame_short, slot0-only result; then a full frame replaying C
        prep();
        vt[0].nid = NID_W'(1);
        vt[1].nid = NID_W'(1);
        vt[1].fs  = 1'b1;
        vt[2].rv  = 1'b1;
        vt[2].chk_out = 1'b1;
        vt[2].ov[0] = 2'b01;
        vt[2].ot[0][0] = 3'd3;
        vt[1].din[0][4] = 1'b1;
        vt[13].col_in[1] = 1'b1;
        vt[14].cout = 2'b10;
        vt[18].ov[1] = 2'b10;
        vt[18].ot[1][1] = 3'd4;
        run_frame("D", 19);

        // E: replay D's [0][4]@t0, record a spike, then rst at fc=6
        prep();
        vt[2].col_in[4] = 1'b1;
        vt[2].din[0][0] = 1'b1;
        run_frame("E", 7);
        tick();
        rst = 1'b1;
        tick();
        check_zero("rst", 0);
        rst = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tick();
            chk("post-rst result_valid", c, 64'(result_valid), 64'd0);
            chk("post-rst col_in", c, 64'(col_in), 64'd0);
        end

        // F: after rst nothing is replayed and the result is all-invalid
        prep();
        run_frame("F", 19);

        // G/H: back-to-back grst every F cycles; q1 spike on the last slot cycle coincides with grst
        prep();
        vt[7].cout = 2'b01;
        run_frame("G", 16);
        prep();
        vt[0].nid = NID_W'(1);
        vt[1].nid = NID_W'(1);
        vt[1].cout = 2'b10;
        vt[2].rv  = 1'b1;
        vt[2].chk_out = 1'b1;
        vt[2].ov[0] = 2'b01;
        vt[2].ov[1] = 2'b10;
        vt[2].ot[0][0] = 3'd5;
        vt[2].ot[1][1] = 3'd7;
        run_frame("H", 19);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
